// File: rtl/sum_byte_packer_pkg.sv
// Shared types and widths for the accumulator output path: sum width, byte width
// and the serializer state encoding.
package sum_pkg;

    localparam int BYTE_W = 8;
    localparam int SUM_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/sum_byte_packer_fifo.sv
// First-word-fall-through FIFO for accumulator sums. A write into a full FIFO is
// discarded and reported through a single-cycle drop pulse.
module sum_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [W-1:0]           wdata,
    input  logic                   rd_en,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;

    // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot for the write.
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign drop  = wr_en && full;

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sum_byte_packer.sv
// Buffers accumulator sums and streams each one as a low byte then a high byte over
// a valid/ready byte interface; a sticky flag records any sum lost to a full FIFO.
module sum_byte_packer
    import sum_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = SUM_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    ser_state_t            state_reg;
    ser_state_t            state_next;
    logic [IN_W-1:0]       hold_reg;
    logic [IN_W-1:0]       hold_next;
    logic [BYTE_W-1:0]     out_data_reg;
    logic [BYTE_W-1:0]     out_data_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic                  overflow_reg;
    logic                  pop;
    logic                  handshake;
    logic                  has_data;
    logic                  fifo_drop;
    logic [IN_W-1:0]       fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [BYTE_W-1:0]     hi_byte;

    sum_fifo #(
        .DEPTH (DEPTH),
        .W     (IN_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (in_valid),
        .wdata (in_data),
        .rd_en (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign handshake = out_valid_reg && out_ready;
    assign has_data  = (fifo_count != '0);
    assign hi_byte   = BYTE_W'(hold_reg >> BYTE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (has_data) state_next = LO;
            LO:      if (handshake) state_next = HI;
            HI:      if (handshake) state_next = has_data ? LO : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // From HI a handshake can pop the next sum directly, so pairs stream without a gap.
    always_comb begin
        pop            = 1'b0;
        hold_next      = hold_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                out_valid_next = 1'b0;
                if (has_data) begin
                    pop            = 1'b1;
                    hold_next      = fifo_rdata;
                    out_data_next  = fifo_rdata[BYTE_W-1:0];
                    out_valid_next = 1'b1;
                end
            end
            LO: begin
                if (handshake) out_data_next = hi_byte;
            end
            HI: begin
                if (handshake) begin
                    if (has_data) begin
                        pop           = 1'b1;
                        hold_next     = fifo_rdata;
                        out_data_next = fifo_rdata[BYTE_W-1:0];
                    end else begin
                        out_valid_next = 1'b0;
                    end
                end
            end
            default: out_valid_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            hold_reg      <= hold_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            if (fifo_drop) overflow_reg <= 1'b1;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign level     = fifo_count;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sum_byte_packer.sv
// Directed bench for sum_byte_packer: single sum, stalled sink, streaming with
// pointer wrap, simultaneous write/pop, overflow and reset in the middle of a pair.
module tb_sum_byte_packer;

    logic       clk;
    logic       rst_n;
    logic [9:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    logic [7:0] byte_q [$];
    int         cyc_q  [$];
    logic [7:0] exp_q  [$];

    sum_byte_packer #(
        .DEPTH (4),
        .IN_W  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bytes are accepted at the next rising edge; inputs are stable from the falling edge on.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            byte_q.push_back(out_data);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("vec %s: got %0h expected %0h ok", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic compare_q(input string tag);
        check_eq({tag, "_count"}, byte_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
            check_eq($sformatf("%s[%0d]", tag, i), byte_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_q();
        byte_q.delete();
        cyc_q.delete();
        exp_q.delete();
    endtask

    logic [9:0] b2b_tab [12] = '{10'h000, 10'h3FF, 10'h100, 10'h0FF, 10'h2AA, 10'h155,
                                 10'h201, 10'h3FE, 10'h080, 10'h37F, 10'h123, 10'h2DC};

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 8'h00);
        check_eq("rst_level", level, 3'd0);
        check_eq("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single sum: A5 then 02, two cycles after the strobe.
        clear_q();
        out_ready = 1'b1;
        strobe(10'h2A5);
        check_eq("single_lvl_n", level, 3'd1);
        check_eq("single_vld_n", out_valid, 1'b0);
        tick();
        check_eq("single_vld_n1", out_valid, 1'b1);
        check_eq("single_lo", out_data, 8'hA5);
        check_eq("single_lvl_n1", level, 3'd0);
        tick();
        check_eq("single_vld_n2", out_valid, 1'b1);
        check_eq("single_hi", out_data, 8'h02);
        tick();
        check_eq("single_vld_n3", out_valid, 1'b0);
        exp_q = '{8'hA5, 8'h02};
        compare_q("single_bytes");

        // Stalled sink holds the low byte.
        clear_q();
        out_ready = 1'b0;
        strobe(10'h3FF);
        tick();
        check_eq("stall_vld", out_valid, 1'b1);
        check_eq("stall_lo", out_data, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("stall_hold%0d", i), {out_valid, out_data}, {1'b1, 8'hFF});
        end
        out_ready = 1'b1;
        tick();
        check_eq("stall_hi", out_data, 8'h03);
        check_eq("stall_hi_vld", out_valid, 1'b1);
        check_eq("stall_lvl", level, 3'd0);
        tick();
        check_eq("stall_done", out_valid, 1'b0);

        // Streaming with pointer wrap, ready sink.
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            strobe(b2b_tab[i]);
            repeat (3) tick();
        end
        repeat (6) tick();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(b2b_tab[i][7:0]);
            exp_q.push_back({6'b0, b2b_tab[i][9:8]});
        end
        compare_q("b2b");
        for (int i = 0; i + 1 < cyc_q.size(); i += 2) begin
            check_eq($sformatf("b2b_gap%0d", i / 2), cyc_q[i+1] - cyc_q[i], 1);
        end
        check_eq("b2b_ovf", overflow, 1'b0);

        // Write on the HI handshake edge while two sums wait.
        clear_q();
        out_ready = 1'b0;
        strobe(10'h0C3);
        tick();
        strobe(10'h1E7);
        tick();
        strobe(10'h2F0);
        tick();
        check_eq("wp_lvl_pre", level, 3'd2);
        check_eq("wp_lo_a", out_data, 8'hC3);
        out_ready = 1'b1;
        tick();
        check_eq("wp_hi_a", out_data, 8'h00);
        strobe(10'h33C);
        check_eq("wp_lvl_same", level, 3'd2);
        check_eq("wp_lo_b", {out_valid, out_data}, {1'b1, 8'hE7});
        repeat (10) tick();
        exp_q = '{8'hC3, 8'h00, 8'hE7, 8'h01, 8'hF0, 8'h02, 8'h3C, 8'h03};
        compare_q("wp_bytes");

        // Overflow: sink stalled, sixth sum is dropped.
        clear_q();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            strobe(10'(k));
            repeat (3) tick();
        end
        check_eq("ovf_lvl4", level, 3'd4);
        check_eq("ovf_before", overflow, 1'b0);
        check_eq("ovf_hold", {out_valid, out_data}, {1'b1, 8'h01});
        strobe(10'd6);
        check_eq("ovf_set", overflow, 1'b1);
        check_eq("ovf_lvl_after", level, 3'd4);
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (20) tick();
        exp_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
        compare_q("ovf_bytes");
        check_eq("ovf_sticky", overflow, 1'b1);
        check_eq("ovf_drained", level, 3'd0);

        // Reset while presenting a high byte.
        clear_q();
        out_ready = 1'b0;
        strobe(10'h3C7);
        tick();
        check_eq("rmid_lo", out_data, 8'hC7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("rmid_hi", {out_valid, out_data}, {1'b1, 8'h03});
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rmid_async_vld", out_valid, 1'b0);
        check_eq("rmid_async_data", out_data, 8'h00);
        check_eq("rmid_async_lvl", level, 3'd0);
        check_eq("rmid_async_ovf", overflow, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
        out_ready = 1'b1;
        strobe(10'h155);
        repeat (5) tick();
        exp_q = '{8'h55, 8'h01};
        compare_q("rmid_bytes");
        check_eq("rmid_ovf_after", overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
